// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module  : regfile_mp
// Purpose : Multi-read-port GPR file with per-register RAW scoreboard,
//           single-level EPC and optional write-to-read bypass
//           (compile with `define REGFILE_BYPASS_EN to enable the bypass).
// Rev     : 1.0
// ============================================================================
module regfile_mp #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NRD      = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_pend,
  input  logic                  iss_vld,
  input  logic [ADDR_W-1:0]     iss_addr,
  input  logic                  wr,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  output logic                  wr_ack,
  output logic [NUM_REGS-1:0]   busy_vec,
  input  logic                  excep,
  input  logic [DATA_W-1:0]     pc,
  input  logic                  eret,
  output logic [DATA_W-1:0]     epc,
  output logic                  epc_vld,
  output logic                  excep_nest
);

  localparam logic [ADDR_W:0] c_num_regs = (ADDR_W+1)'(NUM_REGS);

  logic w_wr_acc;
  logic w_iss_acc;

  assign w_wr_acc  = wr      & en & ({1'b0, wr_addr}  < c_num_regs);
  assign w_iss_acc = iss_vld & en & ({1'b0, iss_addr} < c_num_regs);

  logic [DATA_W-1:0]   gpr_q [NUM_REGS];
  logic [DATA_W-1:0]   gpr_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                wr_ack_q, wr_ack_d;
  logic [DATA_W-1:0]   epc_q, epc_d;
  logic                epc_vld_q, epc_vld_d;
  logic                excep_nest_q, excep_nest_d;

  always_comb begin
    gpr_d    = gpr_q;
    busy_d   = busy_q;
    wr_ack_d = w_wr_acc;
    if (w_wr_acc) begin
      gpr_d[wr_addr]  = wr_data;
      busy_d[wr_addr] = 1'b0;
    end
    // Applied after the clear so a newer producer on the same register wins.
    if (w_iss_acc) begin
      busy_d[iss_addr] = 1'b1;
    end
  end

  always_comb begin
    epc_d        = epc_q;
    epc_vld_d    = epc_vld_q;
    excep_nest_d = 1'b0;
    if (excep) begin
      // A simultaneous eret frees the slot, so the new trap is captured.
      if (!epc_vld_q || eret) begin
        epc_d     = pc;
        epc_vld_d = 1'b1;
      end else begin
        excep_nest_d = 1'b1;
      end
    end else if (eret) begin
      epc_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        gpr_q[r] <= '0;
      end
      busy_q       <= '0;
      wr_ack_q     <= 1'b0;
      epc_q        <= '0;
      epc_vld_q    <= 1'b0;
      excep_nest_q <= 1'b0;
    end else begin
      gpr_q        <= gpr_d;
      busy_q       <= busy_d;
      wr_ack_q     <= wr_ack_d;
      epc_q        <= epc_d;
      epc_vld_q    <= epc_vld_d;
      excep_nest_q <= excep_nest_d;
    end
  end

  generate
    for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [ADDR_W-1:0] w_ra;
      logic [DATA_W-1:0] w_data;
      logic              w_pend;

      assign w_ra = rd_addr[i*ADDR_W +: ADDR_W];

      always_comb begin
        w_data = '0;
        w_pend = 1'b0;
        if (en && ({1'b0, w_ra} < c_num_regs)) begin
`ifdef REGFILE_BYPASS_EN
          if (w_wr_acc && (wr_addr == w_ra)) begin
            w_data = wr_data;
            w_pend = w_iss_acc && (iss_addr == w_ra);
          end else begin
            w_data = gpr_q[w_ra];
            w_pend = busy_q[w_ra];
          end
`else
          w_data = gpr_q[w_ra];
          w_pend = busy_q[w_ra];
`endif
        end
      end

      assign rd_data[i*DATA_W +: DATA_W] = w_data;
      assign rd_pend[i]                  = w_pend;
    end
  endgenerate

  assign wr_ack     = wr_ack_q;
  assign busy_vec   = busy_q;
  assign epc        = epc_q;
  assign epc_vld    = epc_vld_q;
  assign excep_nest = excep_nest_q;

endmodule
`default_nettype wire
